dlsc_pcie_s6_inbound_read_issue: RTL and testbench

Admission and issue stage for inbound PCIe memory reads. It sits between the read command splitter and the AXI AR channel. It admits one split command only when all of the following hold: completion-buffer credits, the outstanding-transaction (MOT) limit, write/read token ordering and completion-header headroom. Compared with the fixed 32-bit engine, it adds a 32/64-bit data path, beat-based credit accounting and read-response timeout detection.

---
 rtl/dlsc_pcie_s6_pkg.sv | 20 ++
 rtl/dlsc_pcie_s6_read_credit.sv | 44 ++++
 rtl/dlsc_pcie_s6_inbound_read_issue.sv | 101 ++++++++++
 tb/tb_dlsc_pcie_s6_inbound_read_issue.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dlsc_pcie_s6_pkg.sv
// dlsc_pcie_s6_pkg: shared AXI encodings and sizing helpers for the inbound read path
package dlsc_pcie_s6_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic bit datab_legal(input int datab);
    return datab == 32 || datab == 64;
  endfunction
  // a 64-bit beat covers two DWORDs, so an odd start DWORD costs an extra half beat
  function automatic int beats_of(input int datab, input logic addr2, input int len);
    return datab == 64 ? (int'(addr2) + len + 1) >> 1 : len;
  endfunction
endpackage

// File: rtl/dlsc_pcie_s6_read_credit.sv
// dlsc_pcie_s6_read_credit: completion-buffer free-beat credits and outstanding-AR counter
module dlsc_pcie_s6_read_credit
  import dlsc_pcie_s6_pkg::*;
#(
  parameter int LEN  = 4,
  parameter int BUFA = 8,
  parameter int MOT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_accept,
  input  logic [LEN:0]        i_beats,
  input  logic                i_pop,
  input  logic                i_r_done,
  output logic                o_credit_ok,
  output logic                o_mot_ok,
  output logic                o_mot_zero,
  output logic [clog2(MOT):0] o_mot_cnt
);
  localparam int W  = (BUFA > LEN ? BUFA : LEN) + 2;
  localparam int FB = BUFA + 1;
  localparam int MB = clog2(MOT) + 1;
  logic [BUFA:0]  r_free;
  logic [MB-1:0]  r_mot;
  logic [W-1:0]   w_free;
  logic [W-1:0]   w_beats;
  assign w_free      = W'(r_free);
  assign w_beats     = W'(i_beats);
  assign o_credit_ok = w_free >= w_beats;
  assign o_mot_ok    = r_mot < MB'(MOT);
  assign o_mot_zero  = r_mot == '0;
  assign o_mot_cnt   = r_mot;
  always_ff @(posedge clk)
    if (rst) begin
      r_free <= {1'b1, {BUFA{1'b0}}};
      r_mot  <= '0;
    end else begin
      r_free <= FB'(w_free - (i_accept ? w_beats : '0) + W'(i_pop));
      r_mot  <= (i_accept && !i_r_done) ? r_mot + 1'b1 :
                (!i_accept && i_r_done && r_mot != '0) ? r_mot - 1'b1 : r_mot;
    end
  assert property (@(posedge clk) disable iff (rst) r_free <= {1'b1, {BUFA{1'b0}}});
  assert property (@(posedge clk) disable iff (rst) i_r_done |-> r_mot != '0);
endmodule

// File: rtl/dlsc_pcie_s6_inbound_read_issue.sv
// dlsc_pcie_s6_inbound_read_issue: admits split read commands and issues them on AXI AR.
// Define DLSC_PCIE_READ_TIMEOUT_EN to build the sticky read-response timeout.
module dlsc_pcie_s6_inbound_read_issue
  import dlsc_pcie_s6_pkg::*;
#(
  parameter int ADDR    = 32,
  parameter int LEN     = 4,
  parameter int DATAB   = 32,
  parameter int BUFA    = 8,
  parameter int MOT     = 16,
  parameter int TOKN    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  output logic                cmd_ready,
  input  logic                cmd_valid,
  input  logic [ADDR-1:2]     cmd_addr,
  input  logic [LEN:0]        cmd_len,
  input  logic                cmd_last,
  input  logic [TOKN-1:0]     cmd_token,
  input  logic                req_pending,
  input  logic [TOKN-1:0]     token_wr,
  output logic [TOKN-1:0]     token_oldest,
  input  logic                resp_almost_full,
  input  logic                axi_ar_ready,
  output logic                axi_ar_valid,
  output logic [ADDR-1:0]     axi_ar_addr,
  output logic [LEN-1:0]      axi_ar_len,
  input  logic                r_beat,
  input  logic                r_last,
  input  logic                buf_pop,
  output logic [clog2(MOT):0] mot_cnt,
  output logic                timeout_err
);
  localparam int AB = clog2(DATAB / 8);
  localparam int LB = LEN + 1;
  logic [LEN:0]    w_beats;
  logic [TOKN-1:0] w_token_diff;
  logic            w_credit_ok, w_mot_ok, w_mot_zero, w_accept, w_to_err;
  logic            r_ar_valid;
  logic [ADDR-1:0] r_ar_addr;
  logic [LEN-1:0]  r_ar_len;
  logic [TOKN-1:0] r_token;
  assign w_beats      = LB'(beats_of(DATAB, cmd_addr[2], int'(cmd_len)));
  // a read may pass only once every write with an older-or-equal token has completed
  assign w_token_diff = token_wr - cmd_token;
  assign cmd_ready    = (!r_ar_valid || axi_ar_ready) && w_credit_ok && !w_token_diff[TOKN-1] &&
                        w_mot_ok && !resp_almost_full && !w_to_err;
  assign w_accept     = cmd_valid && cmd_ready;
  assign axi_ar_valid = r_ar_valid;
  assign axi_ar_addr  = r_ar_addr;
  assign axi_ar_len   = r_ar_len;
  assign token_oldest = r_token;
  assign timeout_err  = w_to_err;
  dlsc_pcie_s6_read_credit #(.LEN(LEN), .BUFA(BUFA), .MOT(MOT)) u_credit (
    .clk        (clk),
    .rst        (rst),
    .i_accept   (w_accept),
    .i_beats    (w_beats),
    .i_pop      (buf_pop),
    .i_r_done   (r_beat && r_last),
    .o_credit_ok(w_credit_ok),
    .o_mot_ok   (w_mot_ok),
    .o_mot_zero (w_mot_zero),
    .o_mot_cnt  (mot_cnt)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_ar_valid <= 1'b0;
      r_ar_addr  <= '0;
      r_ar_len   <= '0;
      r_token    <= '0;
    end else begin
      r_ar_valid <= w_accept || (r_ar_valid && !axi_ar_ready);
      if (w_accept) begin
        r_ar_addr <= {cmd_addr, 2'b00} & ({ADDR{1'b1}} << AB);
        r_ar_len  <= w_beats[LEN-1:0] - 1'b1;
      end
      if (w_accept && cmd_last) r_token <= cmd_token;
      if (!cmd_valid && !req_pending && w_mot_zero) r_token <= token_wr;
    end
`ifdef DLSC_PCIE_READ_TIMEOUT_EN
  localparam int TB = clog2(TIMEOUT) + 1;
  logic [TB-1:0] r_to_cnt;
  logic          r_to_err;
  always_ff @(posedge clk)
    if (rst) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_to_cnt <= (r_beat || w_mot_zero) ? '0 : r_to_err ? r_to_cnt : r_to_cnt + 1'b1;
      r_to_err <= r_to_err || (!r_beat && !w_mot_zero && r_to_cnt == TB'(TIMEOUT - 1));
    end
  assign w_to_err = r_to_err;
`else
  assign w_to_err = 1'b0;
`endif
  assert property (@(posedge clk) datab_legal(DATAB) && MOT >= 2);
  assert property (@(posedge clk) disable iff (rst) cmd_valid |-> w_beats <= LB'(2 ** LEN));
endmodule

// File: tb/tb_dlsc_pcie_s6_inbound_read_issue.sv
// tb_dlsc_pcie_s6_inbound_read_issue: directed checks with DATAB=64, BUFA=4, MOT=2, TIMEOUT=16
module tb_dlsc_pcie_s6_inbound_read_issue;
  logic        clk, rst;
  logic        cmd_ready, cmd_valid, cmd_last, req_pending, resp_almost_full;
  logic [31:2] cmd_addr;
  logic [4:0]  cmd_len;
  logic [3:0]  cmd_token, token_wr, token_oldest;
  logic        axi_ar_ready, axi_ar_valid;
  logic [31:0] axi_ar_addr;
  logic [3:0]  axi_ar_len;
  logic        r_beat, r_last, buf_pop, timeout_err;
  logic [1:0]  mot_cnt;
  int          checks = 0;
  int          errors = 0;

  dlsc_pcie_s6_inbound_read_issue #(
    .ADDR(32), .LEN(4), .DATAB(64), .BUFA(4), .MOT(2), .TOKN(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_last(cmd_last), .cmd_token(cmd_token), .req_pending(req_pending),
    .token_wr(token_wr), .token_oldest(token_oldest), .resp_almost_full(resp_almost_full),
    .axi_ar_ready(axi_ar_ready), .axi_ar_valid(axi_ar_valid), .axi_ar_addr(axi_ar_addr),
    .axi_ar_len(axi_ar_len), .r_beat(r_beat), .r_last(r_last), .buf_pop(buf_pop),
    .mot_cnt(mot_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 0; rst = 1; cmd_valid = 0; cmd_addr = '0; cmd_len = '0; cmd_last = 0;
    cmd_token = '0; req_pending = 1; token_wr = '0; resp_almost_full = 0;
    axi_ar_ready = 1; r_beat = 0; r_last = 0; buf_pop = 0;
    step; step;
    chk("rst_ar_valid", axi_ar_valid, 0);
    chk("rst_ar_addr", axi_ar_addr, 0);
    chk("rst_ar_len", axi_ar_len, 0);
    chk("rst_mot", mot_cnt, 0);
    chk("rst_token", token_oldest, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_free", dut.u_credit.r_free, 16);
    rst = 0;
    // odd DWORD start on a 64-bit bus
    cmd_valid = 1; cmd_addr = 30'h1; cmd_len = 5'd3; #1;
    chk("t1_ready", cmd_ready, 1);
    step; cmd_valid = 0;
    chk("t1_ar_valid", axi_ar_valid, 1);
    chk("t1_ar_addr", axi_ar_addr, 32'h0);
    chk("t1_ar_len", axi_ar_len, 1);
    chk("t1_free", dut.u_credit.r_free, 14);
    chk("t1_mot", mot_cnt, 1);
    r_beat = 1; r_last = 1; buf_pop = 1;
    step;
    chk("t1_ar_clear", axi_ar_valid, 0);
    chk("t1_mot_ret", mot_cnt, 0);
    chk("t1_free_pop", dut.u_credit.r_free, 15);
    r_beat = 0; r_last = 0;
    step; buf_pop = 0;
    chk("t1_free_back", dut.u_credit.r_free, 16);
    // credit exhaustion
    cmd_valid = 1; cmd_addr = 30'h0; cmd_len = 5'd16; #1;
    chk("t2_ready_a", cmd_ready, 1);
    step; #1;
    chk("t2_ready_b", cmd_ready, 1);
    chk("t2_ar_len", axi_ar_len, 7);
    step; cmd_len = 5'd1; r_beat = 1; r_last = 1; #1;
    chk("t2_free0", dut.u_credit.r_free, 0);
    chk("t2_mot2", mot_cnt, 2);
    chk("t2_stall_a", cmd_ready, 0);
    step; #1;
    chk("t2_stall_b", cmd_ready, 0);
    step; r_beat = 0; r_last = 0; #1;
    chk("t2_mot0", mot_cnt, 0);
    chk("t2_stall_credit", cmd_ready, 0);
    buf_pop = 1; step; buf_pop = 0; #1;
    chk("t2_free1", dut.u_credit.r_free, 1);
    chk("t2_ready_pop", cmd_ready, 1);
    step; cmd_valid = 0;
    chk("t2_free_used", dut.u_credit.r_free, 0);
    chk("t2_ar_len1", axi_ar_len, 0);
    chk("t2_mot1", mot_cnt, 1);
    r_beat = 1; r_last = 1; buf_pop = 1;
    step; r_beat = 0; r_last = 0;
    repeat (15) step;
    buf_pop = 0;
    chk("t2_free_restore", dut.u_credit.r_free, 16);
    chk("t2_mot_restore", mot_cnt, 0);
    // outstanding limit
    cmd_valid = 1; cmd_addr = 30'h0; cmd_len = 5'd2;
    step; step; #1;
    chk("t3_mot2", mot_cnt, 2);
    chk("t3_stall_a", cmd_ready, 0);
    step; #1;
    chk("t3_stall_b", cmd_ready, 0);
    r_beat = 1; r_last = 1;
    step; #1;
    chk("t3_mot1", mot_cnt, 1);
    chk("t3_ready", cmd_ready, 1);
    step; r_beat = 0; r_last = 0; cmd_valid = 0;
    chk("t3_mot_same", mot_cnt, 1);
    chk("t3_free", dut.u_credit.r_free, 13);
    r_beat = 1; r_last = 1; buf_pop = 1;
    step; r_beat = 0; r_last = 0;
    step; step; buf_pop = 0;
    chk("t3_mot_restore", mot_cnt, 0);
    chk("t3_free_restore", dut.u_credit.r_free, 16);
    // almost-full headroom
    cmd_valid = 1; cmd_len = 5'd1; resp_almost_full = 1; #1;
    chk("af_stall", cmd_ready, 0);
    resp_almost_full = 0; #1;
    chk("af_ready", cmd_ready, 1);
    cmd_valid = 0;
    // write/read ordering tokens
    token_wr = 4'd3; cmd_token = 4'd5; cmd_last = 1; cmd_valid = 1; cmd_len = 5'd1; cmd_addr = '0; #1;
    chk("t4_tok_stall_a", cmd_ready, 0);
    step; #1;
    chk("t4_tok_stall_b", cmd_ready, 0);
    token_wr = 4'd5; #1;
    chk("t4_tok_ready", cmd_ready, 1);
    step; cmd_valid = 0; cmd_last = 0;
    chk("t4_oldest_cmd", token_oldest, 5);
    token_wr = 4'd9;
    step;
    chk("t4_hold_busy", token_oldest, 5);
    r_beat = 1; r_last = 1;
    step; r_beat = 0; r_last = 0;
    step;
    chk("t4_hold_pending", token_oldest, 5);
    req_pending = 0;
    step;
    chk("t4_follow_wr", token_oldest, 9);
    req_pending = 1; cmd_token = 4'd9; buf_pop = 1;
    step; buf_pop = 0;
    chk("t4_free", dut.u_credit.r_free, 16);
    // AR back-pressure
    axi_ar_ready = 0; cmd_valid = 1; cmd_addr = 30'h5; cmd_len = 5'd4;
    step;
    cmd_addr = 30'h8; cmd_len = 5'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_bp_ready", cmd_ready, 0);
      chk("t5_bp_valid", axi_ar_valid, 1);
      chk("t5_bp_addr", axi_ar_addr, 32'h10);
      chk("t5_bp_len", axi_ar_len, 2);
      step;
    end
    axi_ar_ready = 1; #1;
    chk("t5_ready", cmd_ready, 1);
    step; cmd_valid = 0;
    chk("t5_b2b_valid", axi_ar_valid, 1);
    chk("t5_b2b_addr", axi_ar_addr, 32'h20);
    chk("t5_b2b_len", axi_ar_len, 0);
    chk("t5_mot", mot_cnt, 2);
    chk("t5_free", dut.u_credit.r_free, 12);
    step;
    chk("t5_clear", axi_ar_valid, 0);
    r_beat = 1; r_last = 1; buf_pop = 1;
    step; step; r_beat = 0; r_last = 0;
    step; step; buf_pop = 0;
    chk("t5_mot_restore", mot_cnt, 0);
    chk("t5_free_restore", dut.u_credit.r_free, 16);
    // silent read response
    cmd_valid = 1; cmd_len = 5'd1; cmd_addr = '0;
    step; cmd_valid = 0;
    repeat (15) step;
    chk("t6_no_err_yet", timeout_err, 0);
    step;
`ifdef DLSC_PCIE_READ_TIMEOUT_EN
    chk("t6_err", timeout_err, 1);
    cmd_valid = 1; #1;
    chk("t6_blocked", cmd_ready, 0);
    step; cmd_valid = 0;
    chk("t6_no_accept", mot_cnt, 1);
    chk("t6_ar_done", axi_ar_valid, 0);
`else
    chk("t6_err_off", timeout_err, 0);
    cmd_valid = 1; #1;
    chk("t6_not_blocked", cmd_ready, 1);
    cmd_valid = 0;
`endif
    rst = 1;
    step; rst = 0;
    chk("end_timeout", timeout_err, 0);
    chk("end_mot", mot_cnt, 0);
    chk("end_free", dut.u_credit.r_free, 16);
    chk("end_ar_valid", axi_ar_valid, 0);
    chk("end_token", token_oldest, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
